mem_read_arbiter: RTL

Parametrised arbiter merging N_CH read clients (instruction fetch, LSU, future prefetchers) onto the single CPU-level memory read port, with a registered write pass-through. Tracks outstanding reads in an in-order tag FIFO so returning data is routed to the issuing client. A per-channel flush discards stale in-flight responses (e.g. fetch redirect). Sits between the fetch stage and inst_router LSU on one side and the top-level mem_* ports on the other.

---
 rtl/mem_read_arbiter_pkg.sv | 19 +
 rtl/mem_read_arbiter_if.sv | 16 +
 rtl/mem_read_arbiter_rr_arbiter.sv | 30 +++
 rtl/mem_read_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// rtl/mem_read_arbiter_pkg.sv - shared constants, tag type and width helper for the read arbiter
package mem_read_arbiter_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Tag channel field is sized for the largest supported client count.
  localparam int TAG_CH_W  = 8;

  typedef struct packed {
    logic [TAG_CH_W-1:0] ch;
    logic                discard;
  } tag_t;

  function automatic int clamp_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// rtl/mem_read_arbiter_if.sv - CPU-level memory read/write port bundle
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (output ren, raddr, wen, waddr, wdata, input rvalid, rdata);
  modport slave  (input ren, raddr, wen, waddr, wdata, output rvalid, rdata);
endinterface

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// rtl/mem_read_arbiter_rr_arbiter.sv - round-robin / fixed-priority one-hot grant
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             fixed_prio,
  output logic [N-1:0]     grant
);

  int best;
  int rank;

  // Rank is the distance from the priority start; the smallest ranked requester wins.
  always_comb begin
    grant = '0;
    best  = N;
    rank  = 0;
    for (int i = 0; i < N; i++) begin
      rank = fixed_prio ? i : (i + N - int'(ptr)) % N;
      if (req[i] && rank < best) begin
        best     = rank;
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - merges N_CH read clients onto one memory port with in-order tag routing
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = ARB_RR
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_CH-1:0]                        req_ren,
  input  logic [ADDR_W-1:0]                      req_raddr [N_CH],
  output logic [N_CH-1:0]                        req_rready,
  output logic [N_CH-1:0]                        req_rvalid,
  output logic [DATA_W-1:0]                      req_rdata [N_CH],
  input  logic [N_CH-1:0]                        req_flush,
  input  logic                                   wr_wen,
  input  logic [ADDR_W-1:0]                      wr_waddr,
  input  logic [DATA_W-1:0]                      wr_wdata,
  mem_read_arbiter_if.master                     mem,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_unexpected_rvalid
);

  localparam int CH_W  = clamp_clog2(N_CH);
  localparam int PTR_W = clamp_clog2(MAX_OUTSTANDING);
  localparam int OCC_W = $clog2(MAX_OUTSTANDING+1);

  tag_t                       fifo [MAX_OUTSTANDING];
  tag_t                       head;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [CH_W-1:0]            rr_ptr;
  logic [CH_W-1:0]            grant_idx;
  logic [N_CH-1:0]            grant;
  logic [MAX_OUTSTANDING-1:0] entry_flush;
  logic                       space;
  logic                       accept;
  logic                       pop;
  logic                       head_discard;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == MAX_OUTSTANDING-1) ? '0 : p + 1'b1;
  endfunction

  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign space = (int'(outstanding) < MAX_OUTSTANDING) || mem.rvalid;
  assign pop   = mem.rvalid && (outstanding != '0);
  assign head  = fifo[rd_ptr];

  rr_arbiter #(
    .N     (N_CH),
    .PTR_W (CH_W)
  ) u_rr_arbiter (
    .req        (req_ren & {N_CH{space}}),
    .ptr        (rr_ptr),
    .fixed_prio (ARB_MODE == ARB_FIXED),
    .grant      (grant)
  );

  assign accept     = |grant;
  assign req_rready = grant;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant[i]) grant_idx = CH_W'(i);
  end

  // Flush reaches the head combinationally so a response racing a redirect is dropped.
  always_comb begin
    head_discard = head.discard;
    for (int i = 0; i < N_CH; i++)
      if (req_flush[i] && int'(head.ch) == i) head_discard = 1'b1;
  end

  always_comb begin
    req_rvalid = '0;
    for (int i = 0; i < N_CH; i++) begin
      req_rvalid[i] = pop && !head_discard && (int'(head.ch) == i);
      req_rdata[i]  = mem.rdata;
    end
  end

  always_comb begin
    entry_flush = '0;
    for (int e = 0; e < MAX_OUTSTANDING; e++)
      for (int i = 0; i < N_CH; i++)
        if (req_flush[i] && int'(fifo[e].ch) == i) entry_flush[e] = 1'b1;
  end

  // The push is written after the flush so a post-redirect request keeps discard clear.
  always_ff @(posedge clk) begin
    for (int e = 0; e < MAX_OUTSTANDING; e++)
      if (entry_flush[e]) fifo[e].discard <= 1'b1;
    if (accept) fifo[wr_ptr] <= '{ch: TAG_CH_W'(grant_idx), discard: 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr                <= '0;
      wr_ptr                <= '0;
      outstanding           <= '0;
      rr_ptr                <= '0;
      err_unexpected_rvalid <= 1'b0;
    end else begin
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      outstanding <= outstanding + OCC_W'(accept) - OCC_W'(pop);
      if (mem.rvalid && outstanding == '0) err_unexpected_rvalid <= 1'b1;
      if (ARB_MODE == ARB_RR && accept)
        rr_ptr <= (int'(grant_idx) == N_CH-1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem.ren   <= 1'b0;
      mem.raddr <= '0;
      mem.wen   <= 1'b0;
      mem.waddr <= '0;
      mem.wdata <= '0;
    end else begin
      mem.ren <= accept;
      if (accept) mem.raddr <= req_raddr[grant_idx];
      mem.wen   <= wr_wen;
      mem.waddr <= wr_waddr;
      mem.wdata <= wr_wdata;
    end
  end

endmodule
